// File: rtl/game_screen_sequencer.sv
// Screen sequencer for the OLED game path: picks one of NUM_SCREENS pixel streams,
// with edge-detected next/prev navigation, optional wrap, auto-advance and blanking.
module game_screen_sequencer #(
    parameter int NUM_SCREENS  = 13,
    parameter int IDX_W        = 4,
    parameter int AUTO_CYCLES  = 0,
    parameter int BLANK_CYCLES = 0,
    parameter int WRAP         = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      sw,
    input  logic                      btnR,
    input  logic                      btnL,
    input  logic [NUM_SCREENS*16-1:0] screen_data,
    output logic [15:0]               oled_data,
    output logic [IDX_W-1:0]          screen_idx,
    output logic                      active,
    output logic                      changed
);
    localparam int TW = (AUTO_CYCLES > 1) ? $clog2(AUTO_CYCLES) : 1;
    localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [TW-1:0]    T_LAST   = TW'((AUTO_CYCLES > 0) ? AUTO_CYCLES - 1 : 0);
    localparam logic [BW-1:0]    B_LAST   = BW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_SCREENS - 1);

    typedef enum logic [1:0] {IDLE, SHOW, BLANK} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [BW-1:0]    blank_q, blank_d;
    logic             changed_q, changed_d;
    logic             btnR_q, btnL_q;

    logic             pressR, pressL, btn_ev, auto_ev;
    logic [IDX_W-1:0] next_idx, prev_idx, target;
    logic [15:0]      sel_pixel;

    assign pressR = btnR & ~btnR_q;
    assign pressL = btnL & ~btnL_q;

    // Ends are detected by compare against the last index, so a non-power-of-two count wraps correctly.
    assign next_idx = (idx_q == IDX_LAST) ? ((WRAP != 0) ? '0 : idx_q) : idx_q + 1'b1;
    assign prev_idx = (idx_q == '0) ? ((WRAP != 0) ? IDX_LAST : idx_q) : idx_q - 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            timer_q   <= '0;
            blank_q   <= '0;
            changed_q <= 1'b0;
            btnR_q    <= 1'b1;
            btnL_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            timer_q   <= timer_d;
            blank_q   <= blank_d;
            changed_q <= changed_d;
            btnR_q    <= btnR;
            btnL_q    <= btnL;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        timer_d   = timer_q;
        blank_d   = blank_q;
        changed_d = 1'b0;
        btn_ev    = 1'b0;
        auto_ev   = 1'b0;
        target    = idx_q;
        if (!sw) begin
            state_d = IDLE;
            idx_d   = '0;
            timer_d = '0;
            blank_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = SHOW;
                    idx_d   = '0;
                    timer_d = '0;
                    blank_d = '0;
                end
                SHOW: begin
                    // Simultaneous presses cancel each other; a lone press beats the timeout.
                    if (pressR ^ pressL) begin
                        btn_ev = 1'b1;
                        target = pressR ? next_idx : prev_idx;
                    end else if ((AUTO_CYCLES > 0) && (timer_q == T_LAST)) begin
                        auto_ev = 1'b1;
                        target  = next_idx;
                    end
                    if ((btn_ev || auto_ev) && (target != idx_q)) begin
                        idx_d     = target;
                        changed_d = 1'b1;
                        timer_d   = '0;
                        if (BLANK_CYCLES > 0) begin
                            state_d = BLANK;
                            blank_d = '0;
                        end
                    end else if (btn_ev) begin
                        timer_d = '0;
                    end else if ((AUTO_CYCLES > 0) && (timer_q != T_LAST)) begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                BLANK: begin
                    if (blank_q == B_LAST) begin
                        state_d = SHOW;
                        timer_d = '0;
                        blank_d = '0;
                    end else begin
                        blank_d = blank_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        sel_pixel = 16'h0000;
        for (int i = 0; i < NUM_SCREENS; i++) begin
            if (idx_q == IDX_W'(i)) sel_pixel = screen_data[16*i +: 16];
        end
    end

    assign oled_data  = (state_q == SHOW) ? sel_pixel : 16'h0000;
    assign active     = (state_q == SHOW);
    assign screen_idx = idx_q;
    assign changed    = changed_q;

endmodule

// File: tb/tb_game_screen_sequencer.sv
// Randomized and directed bench: five sequencer configurations share one stimulus
// stream and are each compared every cycle against a behavioural model.
module tb_game_screen_sequencer;
    localparam int NC = 5;
    localparam int P_N [NC] = '{4, 4, 4, 4, 13};
    localparam int P_W [NC] = '{1, 0, 1, 1, 0};
    localparam int P_A [NC] = '{0, 0, 10, 0, 7};
    localparam int P_B [NC] = '{0, 0, 0, 3, 3};

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         sw = 1'b0;
    logic         btnR = 1'b1;
    logic         btnL = 1'b0;
    logic [207:0] sd = '0;

    logic [15:0] d_oled [NC];
    logic [3:0]  d_idx  [NC];
    logic        d_act  [NC];
    logic        d_chg  [NC];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    game_screen_sequencer #(.NUM_SCREENS(4), .IDX_W(4), .AUTO_CYCLES(0), .BLANK_CYCLES(0), .WRAP(1)) u0 (
        .clk(clk), .rst(rst), .sw(sw), .btnR(btnR), .btnL(btnL), .screen_data(sd[63:0]),
        .oled_data(d_oled[0]), .screen_idx(d_idx[0]), .active(d_act[0]), .changed(d_chg[0]));
    game_screen_sequencer #(.NUM_SCREENS(4), .IDX_W(4), .AUTO_CYCLES(0), .BLANK_CYCLES(0), .WRAP(0)) u1 (
        .clk(clk), .rst(rst), .sw(sw), .btnR(btnR), .btnL(btnL), .screen_data(sd[63:0]),
        .oled_data(d_oled[1]), .screen_idx(d_idx[1]), .active(d_act[1]), .changed(d_chg[1]));
    game_screen_sequencer #(.NUM_SCREENS(4), .IDX_W(4), .AUTO_CYCLES(10), .BLANK_CYCLES(0), .WRAP(1)) u2 (
        .clk(clk), .rst(rst), .sw(sw), .btnR(btnR), .btnL(btnL), .screen_data(sd[63:0]),
        .oled_data(d_oled[2]), .screen_idx(d_idx[2]), .active(d_act[2]), .changed(d_chg[2]));
    game_screen_sequencer #(.NUM_SCREENS(4), .IDX_W(4), .AUTO_CYCLES(0), .BLANK_CYCLES(3), .WRAP(1)) u3 (
        .clk(clk), .rst(rst), .sw(sw), .btnR(btnR), .btnL(btnL), .screen_data(sd[63:0]),
        .oled_data(d_oled[3]), .screen_idx(d_idx[3]), .active(d_act[3]), .changed(d_chg[3]));
    game_screen_sequencer #(.NUM_SCREENS(13), .IDX_W(4), .AUTO_CYCLES(7), .BLANK_CYCLES(3), .WRAP(0)) u4 (
        .clk(clk), .rst(rst), .sw(sw), .btnR(btnR), .btnL(btnL), .screen_data(sd),
        .oled_data(d_oled[4]), .screen_idx(d_idx[4]), .active(d_act[4]), .changed(d_chg[4]));

    // Model: mode 0 = off, 1 = showing, 2 = blanking.
    int m_mode [NC];
    int m_idx  [NC];
    int m_tmr  [NC];
    int m_blk  [NC];
    int m_chg  [NC];
    bit m_prevR = 1'b1;
    bit m_prevL = 1'b1;

    function automatic int step_fwd(int i, int n, int w);
        if (i == n - 1) return (w != 0) ? 0 : i;
        return i + 1;
    endfunction

    function automatic int step_back(int i, int n, int w);
        if (i == 0) return (w != 0) ? n - 1 : 0;
        return i - 1;
    endfunction

    always @(posedge clk) begin : model
        bit pr, pl;
        int tgt, ev;
        if (rst) begin
            for (int c = 0; c < NC; c++) begin
                m_mode[c] = 0; m_idx[c] = 0; m_tmr[c] = 0; m_blk[c] = 0; m_chg[c] = 0;
            end
            m_prevR = 1'b1;
            m_prevL = 1'b1;
        end else begin
            pr = btnR && !m_prevR;
            pl = btnL && !m_prevL;
            for (int c = 0; c < NC; c++) begin
                m_chg[c] = 0;
                if (!sw) begin
                    m_mode[c] = 0; m_idx[c] = 0; m_tmr[c] = 0; m_blk[c] = 0;
                end else if (m_mode[c] == 0) begin
                    m_mode[c] = 1; m_idx[c] = 0; m_tmr[c] = 0; m_blk[c] = 0;
                end else if (m_mode[c] == 1) begin
                    ev = 0;
                    tgt = m_idx[c];
                    if (pr != pl) begin
                        ev = 1;
                        tgt = pr ? step_fwd(m_idx[c], P_N[c], P_W[c]) : step_back(m_idx[c], P_N[c], P_W[c]);
                    end else if (P_A[c] > 0 && m_tmr[c] == P_A[c] - 1) begin
                        ev = 2;
                        tgt = step_fwd(m_idx[c], P_N[c], P_W[c]);
                    end
                    if (ev != 0 && tgt != m_idx[c]) begin
                        m_idx[c] = tgt;
                        m_chg[c] = 1;
                        m_tmr[c] = 0;
                        if (P_B[c] > 0) begin
                            m_mode[c] = 2;
                            m_blk[c] = 0;
                        end
                    end else if (ev == 1) begin
                        m_tmr[c] = 0;
                    end else if (P_A[c] > 0 && m_tmr[c] < P_A[c] - 1) begin
                        m_tmr[c] = m_tmr[c] + 1;
                    end
                end else begin
                    m_blk[c] = m_blk[c] + 1;
                    if (m_blk[c] == P_B[c]) begin
                        m_mode[c] = 1; m_tmr[c] = 0; m_blk[c] = 0;
                    end
                end
            end
            m_prevR = btnR;
            m_prevL = btnL;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic compare_all();
        logic [15:0] e_oled;
        for (int c = 0; c < NC; c++) begin
            e_oled = (m_mode[c] == 1) ? sd[16*m_idx[c] +: 16] : 16'h0000;
            chk($sformatf("cfg%0d.oled", c), 32'(d_oled[c]), 32'(e_oled));
            chk($sformatf("cfg%0d.idx", c), 32'(d_idx[c]), 32'(m_idx[c]));
            chk($sformatf("cfg%0d.active", c), 32'(d_act[c]), 32'(m_mode[c] == 1));
            chk($sformatf("cfg%0d.changed", c), 32'(d_chg[c]), 32'(m_chg[c]));
        end
    endtask

    task automatic cyc(input logic r, input logic s, input logic bR, input logic bL);
        @(posedge clk);
        #1;
        rst = r; sw = s; btnR = bR; btnL = bL;
        @(negedge clk);
        compare_all();
    endtask

    task automatic pulseR();
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        logic [15:0] exp_pix [4];
        int          exp_i0  [4];
        int          exp_i1  [4];
        exp_pix = '{16'h2222, 16'h3333, 16'h4444, 16'h1111};
        exp_i0  = '{1, 2, 3, 0};
        exp_i1  = '{1, 2, 3, 3};
        sd[63:0] = 64'h4444_3333_2222_1111;

        // Reset with btnR held high throughout.
        repeat (3) cyc(1'b1, 1'b0, 1'b1, 1'b0);
        chk("rst.idx", 32'(d_idx[0]), 32'd0);
        chk("rst.oled", 32'(d_oled[0]), 32'h0);
        chk("rst.active", 32'(d_act[0]), 32'd0);
        chk("rst.changed", 32'(d_chg[0]), 32'd0);

        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        chk("enter.active", 32'(d_act[0]), 32'd1);
        chk("enter.oled", 32'(d_oled[0]), 32'h1111);
        repeat (3) cyc(1'b0, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        chk("held_through_rst.idx", 32'(d_idx[0]), 32'd0);

        for (int k = 0; k < 4; k++) begin
            pulseR();
            chk($sformatf("pulse%0d.idx", k), 32'(d_idx[0]), 32'(exp_i0[k]));
            chk($sformatf("pulse%0d.oled", k), 32'(d_oled[0]), 32'(exp_pix[k]));
            chk($sformatf("pulse%0d.changed", k), 32'(d_chg[0]), 32'd1);
            chk($sformatf("pulse%0d.nowrap_idx", k), 32'(d_idx[1]), 32'(exp_i1[k]));
        end
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        chk("pulse_end.changed", 32'(d_chg[0]), 32'd0);

        // Held button gives exactly one advance.
        repeat (20) cyc(1'b0, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        chk("hold.idx", 32'(d_idx[0]), 32'd1);

        // Change on the blanking config, then drop sw while it is black.
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("blank.active", 32'(d_act[3]), 32'd0);
        chk("blank.oled", 32'(d_oled[3]), 32'h0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        chk("sw_off.idx", 32'(d_idx[3]), 32'd0);
        chk("sw_off.active", 32'(d_act[3]), 32'd0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        chk("sw_on.active", 32'(d_act[3]), 32'd1);
        chk("sw_on.oled", 32'(d_oled[3]), 32'h1111);

        // Reset while showing screen 2.
        pulseR();
        pulseR();
        chk("pre_rst.idx", 32'(d_idx[0]), 32'd2);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        chk("mid_rst.idx", 32'(d_idx[0]), 32'd0);
        chk("mid_rst.active", 32'(d_act[0]), 32'd0);

        // Long idle stretch exercises auto-advance.
        repeat (40) cyc(1'b0, 1'b1, 1'b0, 1'b0);

        for (int n = 0; n < 4000; n++) begin
            for (int s = 0; s < 13; s++) sd[16*s +: 16] = 16'($urandom);
            cyc(($urandom % 250) == 0, ($urandom % 120) != 0,
                ($urandom % 4) == 0, ($urandom % 5) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
